serial_byte_deser: RTL and testbench



---
 rtl/serial_byte_deser.sv | 138 +++++++++++++
 tb/tb_serial_byte_deser.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_byte_deser.sv
// serial_byte_deser: LSB-first serial-to-parallel deserializer with sync-marker framing and a show-ahead FIFO
//   clk, reset (async, active-high)      clock and reset
//   bit_in, bit_en, sync                 serial bit, bit qualifier, frame-start marker (qualified by bit_en)
//   data_out, data_valid, data_ready     FIFO head word and valid/ready handshake
//   fifo_count                           occupied FIFO entries, 0..FIFO_DEPTH
//   overflow, ovf_clr                    sticky dropped-frame flag and its clear
//   parity_err                           one-cycle pulse on a bad parity bit
// Optional feature: define SERIAL_BYTE_DESER_PARITY_EN to append an even-parity bit to each frame.
module serial_byte_deser #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          bit_in,
    input  logic                          bit_en,
    input  logic                          sync,
    output logic [DATA_W-1:0]             data_out,
    output logic                          data_valid,
    input  logic                          data_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    input  logic                          ovf_clr,
    output logic                          parity_err
);
    localparam int CW = $clog2(DATA_W);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int NW = AW + 1;
    localparam logic [1:0] HUNT = 2'd0;
    localparam logic [1:0] DATA = 2'd1;
`ifdef SERIAL_BYTE_DESER_PARITY_EN
    localparam logic [1:0] PAR  = 2'd2;
    logic perr_q, perr_d;
`endif
    logic [1:0]        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
    logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
    logic [NW-1:0]     count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              push, do_push, pop, full;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        push    = 1'b0;
`ifdef SERIAL_BYTE_DESER_PARITY_EN
        perr_d  = 1'b0;
`endif
        if (bit_en) begin
            // a sync bit restarts framing from any state, silently dropping a partial frame
            if (sync) begin
                shift_d    = '0;
                shift_d[0] = bit_in;
                cnt_d      = CW'(1);
                state_d    = DATA;
            end else if (state_q == DATA) begin
                shift_d[cnt_q] = bit_in;
                cnt_d          = cnt_q + CW'(1);
                if (cnt_q == CW'(DATA_W - 1)) begin
                    cnt_d = '0;
`ifdef SERIAL_BYTE_DESER_PARITY_EN
                    state_d = PAR;
`else
                    push = 1'b1;
`endif
                end
            end
`ifdef SERIAL_BYTE_DESER_PARITY_EN
            else if (state_q == PAR) begin
                cnt_d   = '0;
                state_d = DATA;
                if (^{shift_q, bit_in})
                    perr_d = 1'b1;
                else
                    push = 1'b1;
            end
`endif
        end
    end

    assign data_valid = count_q != '0;
    assign full       = count_q == NW'(FIFO_DEPTH);
    assign pop        = data_valid && data_ready;
    // a pop in the same cycle frees the slot a push into a full FIFO needs
    assign do_push    = push && (!full || pop);

    always_comb begin
        mem_d = mem_q;
        if (do_push)
            mem_d[wr_q] = shift_d;
        wr_d    = wr_q + AW'(do_push);
        rd_d    = rd_q + AW'(pop);
        count_d = count_q + NW'(do_push) - NW'(pop);
        ovf_d   = (push && !do_push) || (ovf_q && !ovf_clr);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= HUNT;
            cnt_q   <= '0;
            shift_q <= '0;
            mem_q   <= '{default: '0};
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
`ifdef SERIAL_BYTE_DESER_PARITY_EN
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
`ifdef SERIAL_BYTE_DESER_PARITY_EN
            perr_q  <= perr_d;
`endif
        end
    end

    // head is gated so an empty FIFO presents zero rather than stale contents
    assign data_out   = data_valid ? mem_q[rd_q] : '0;
    assign fifo_count = count_q;
    assign overflow   = ovf_q;
`ifdef SERIAL_BYTE_DESER_PARITY_EN
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_serial_byte_deser.sv
// tb_serial_byte_deser: directed bench for serial_byte_deser in its default (no parity) build
module tb_serial_byte_deser;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       bit_in = 1'b0, bit_en = 1'b0, sync = 1'b0, data_ready = 1'b0, ovf_clr = 1'b0;
    logic [7:0] data_out;
    logic       data_valid, overflow, parity_err;
    logic [2:0] fifo_count;
    int         n_cmp = 0, n_err = 0;

    typedef struct {
        logic       en, s, b, rdy;
        logic       ev;
        logic [7:0] ed;
        logic [2:0] ec;
    } vec_t;
    vec_t tbl[22];

    serial_byte_deser dut (
        .clk(clk), .reset(reset), .bit_in(bit_in), .bit_en(bit_en), .sync(sync),
        .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
        .fifo_count(fifo_count), .overflow(overflow), .ovf_clr(ovf_clr), .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        bit_en = 0; sync = 0; bit_in = 0; data_ready = 0; ovf_clr = 0;
    endtask

    task automatic do_reset;
        idle();
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    task automatic send_bits(input logic [7:0] d, input int n, input bit s, input bit rdy_last, input bit gap);
        for (int i = 0; i < n; i++) begin
            if (gap) begin
                bit_en = 0; sync = 0; data_ready = 0;
                tick();
            end
            bit_en = 1; sync = s && (i == 0); bit_in = d[i]; data_ready = (i == n - 1) && rdy_last;
            tick();
        end
        bit_en = 0; sync = 0; data_ready = 0;
    endtask

    task automatic send_byte(input logic [7:0] d, input bit s, input bit rdy_last);
        send_bits(d, 8, s, rdy_last, 1'b0);
    endtask

    initial begin
        logic [7:0] drain [4];
        drain = '{8'h02, 8'h03, 8'h04, 8'h06};
        // HUNT noise, 0xA5 with sync (LSB first 1,0,1,0,0,1,0,1), pop, then 0x3C with no sync
        tbl[0]  = '{1, 0, 1, 1, 0, 8'h00, 3'd0};
        tbl[1]  = '{1, 0, 0, 1, 0, 8'h00, 3'd0};
        tbl[2]  = '{0, 1, 1, 1, 0, 8'h00, 3'd0};
        tbl[3]  = '{1, 1, 1, 1, 0, 8'h00, 3'd0};
        tbl[4]  = '{1, 0, 0, 1, 0, 8'h00, 3'd0};
        tbl[5]  = '{1, 0, 1, 1, 0, 8'h00, 3'd0};
        tbl[6]  = '{1, 0, 0, 1, 0, 8'h00, 3'd0};
        tbl[7]  = '{1, 0, 0, 1, 0, 8'h00, 3'd0};
        tbl[8]  = '{1, 0, 1, 1, 0, 8'h00, 3'd0};
        tbl[9]  = '{1, 0, 0, 1, 0, 8'h00, 3'd0};
        tbl[10] = '{1, 0, 1, 1, 1, 8'hA5, 3'd1};
        tbl[11] = '{0, 0, 0, 1, 0, 8'h00, 3'd0};
        tbl[12] = '{1, 0, 0, 0, 0, 8'h00, 3'd0};
        tbl[13] = '{1, 0, 0, 0, 0, 8'h00, 3'd0};
        tbl[14] = '{0, 0, 1, 0, 0, 8'h00, 3'd0};
        tbl[15] = '{1, 0, 1, 0, 0, 8'h00, 3'd0};
        tbl[16] = '{1, 0, 1, 0, 0, 8'h00, 3'd0};
        tbl[17] = '{1, 0, 1, 0, 0, 8'h00, 3'd0};
        tbl[18] = '{1, 0, 1, 0, 0, 8'h00, 3'd0};
        tbl[19] = '{1, 0, 0, 0, 0, 8'h00, 3'd0};
        tbl[20] = '{1, 0, 0, 0, 1, 8'h3C, 3'd1};
        tbl[21] = '{0, 0, 0, 1, 0, 8'h00, 3'd0};

        do_reset();
        chk("rst_valid", data_valid, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_data", data_out, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_perr", parity_err, 0);

        for (int i = 0; i < 22; i++) begin
            bit_en = tbl[i].en; sync = tbl[i].s; bit_in = tbl[i].b; data_ready = tbl[i].rdy;
            tick();
            chk($sformatf("vec%0d_valid", i), data_valid, tbl[i].ev);
            chk($sformatf("vec%0d_count", i), fifo_count, tbl[i].ec);
            if (tbl[i].ev)
                chk($sformatf("vec%0d_data", i), data_out, tbl[i].ed);
        end
        idle();

        do_reset();
        for (int i = 0; i < 20; i++) begin
            bit_en = 1; sync = 0; bit_in = 1'($urandom_range(0, 1));
            tick();
        end
        chk("noise_count", fifo_count, 0);
        send_byte(8'h3C, 1, 0);
        chk("noise_3c_count", fifo_count, 1);
        chk("noise_3c_data", data_out, 8'h3C);
        data_ready = 1;
        tick();
        data_ready = 0;
        chk("noise_pop_count", fifo_count, 0);
        chk("noise_pop_valid", data_valid, 0);

        do_reset();
        send_byte(8'h01, 1, 0);
        send_byte(8'h02, 0, 0);
        send_byte(8'h03, 0, 0);
        send_byte(8'h04, 0, 0);
        chk("fill_count", fifo_count, 4);
        chk("fill_ovf", overflow, 0);
        send_byte(8'h05, 0, 0);
        chk("drop_count", fifo_count, 4);
        chk("drop_ovf", overflow, 1);
        chk("drop_head", data_out, 8'h01);
        send_byte(8'h06, 0, 1);
        chk("full_pushpop_count", fifo_count, 4);
        chk("full_pushpop_head", data_out, 8'h02);
        chk("full_pushpop_ovf", overflow, 1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain%0d_data", i), data_out, drain[i]);
            data_ready = 1;
            tick();
            data_ready = 0;
        end
        chk("drain_count", fifo_count, 0);
        data_ready = 1;
        tick();
        data_ready = 0;
        chk("underflow_count", fifo_count, 0);
        chk("ovf_sticky", overflow, 1);
        ovf_clr = 1;
        tick();
        ovf_clr = 0;
        chk("ovf_clr", overflow, 0);
        for (int i = 0; i < 4; i++)
            send_byte(8'(8'h10 + i), 0, 0);
        ovf_clr = 1;
        send_byte(8'h14, 0, 0);
        ovf_clr = 0;
        chk("ovf_set_wins", overflow, 1);

        do_reset();
        send_bits(8'hFF, 4, 1, 0, 0);
        send_byte(8'h7E, 1, 0);
        chk("resync_count", fifo_count, 1);
        chk("resync_data", data_out, 8'h7E);

        do_reset();
        send_bits(8'hC3, 7, 1, 0, 1);
        chk("gap_pre_valid", data_valid, 0);
        tick();
        bit_en = 1; bit_in = 1;
        tick();
        bit_en = 0;
        chk("gap_valid", data_valid, 1);
        chk("gap_data", data_out, 8'hC3);
        send_byte(8'h5A, 0, 0);
        chk("two_count", fifo_count, 2);
        send_byte(8'h99, 0, 1);
        chk("pushpop_count", fifo_count, 2);
        chk("pushpop_head", data_out, 8'h5A);

        send_bits(8'hFF, 3, 0, 0, 0);
        #2;
        reset = 1;
        #1;
        chk("async_rst_count", fifo_count, 0);
        chk("async_rst_valid", data_valid, 0);
        chk("async_rst_data", data_out, 0);
        tick();
        reset = 0;
        send_byte(8'hFF, 0, 0);
        chk("post_rst_hunt", fifo_count, 0);
        send_byte(8'h81, 1, 0);
        chk("post_rst_data", data_out, 8'h81);
        chk("perr_quiet", parity_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
